load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory interface: accepts load/store requests from the datapath,
//  sequences the word-addressed data memory (combinational read, posedge write), and returns
//  load data. Adds byte/halfword access (LB/LBU/LH/LHU/SB/SH) over the word-only memory.
//  Sub-word stores use read-modify-write. Misaligned, out-of-range and bad-size requests are
//  flagged and never reach memory. Sits between the execute stage and the data memory.
// PARAMETERS
//  MEM_WORDS   512  depth of attached data memory in 32-bit words; byte addr >= 4*MEM_WORDS is out of range
//  ADDR_WIDTH  32   byte-address width on request and memory sides
// PORTS
//  clk             in   1   single clock, all state updates on posedge
//  rst             in   1   synchronous, active-high reset
//  req_valid       in   1   request present
//  req_ready       out  1   unit can accept (high only in IDLE)
//  req_write       in   1   1=store, 0=load
//  req_size        in   2   00=byte, 01=half, 10=word, 11=reserved
//  req_signed      in   1   loads only: 1=sign-extend, 0=zero-extend
//  req_addr        in   32  byte address
//  req_wdata       in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  resp_valid      out  1   one-cycle pulse: request completed
//  resp_rdata      out  32  extended load data; 0 for stores and errors
//  resp_err        out  2   00=ok, 01=misaligned, 10=out of range, 11=bad size
//  mem_address     out  32  word-aligned byte address to memory ({addr[31:2],2'b00})
//  mem_write_data  out  32  full word to memory
//  mem_read        out  1   memory read enable
//  mem_write       out  1   memory write enable (sampled by memory at posedge)
//  mem_read_data   in   32  memory read data, valid combinationally while mem_read=1
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=00; mem_read=0; mem_write=0;
//    mem_address=0; mem_write_data=0. All memory-side outputs are 0 in every state except RD/WR.
//  - FSM: IDLE, RD, WR, RESP. Accept on the edge where req_valid && req_ready; request is
//    latched. Check priority: bad size > misaligned (half addr[0]!=0, word addr[1:0]!=0) > out of range.
//  - IDLE -> RESP on error (no memory access, resp_err set). -> RD for loads and for byte/half stores.
//    -> WR for word stores.
//  - RD: mem_read=1. Word captured into rd_q at the closing edge. Load -> RESP. Sub-word store -> WR.
//  - WR: mem_write=1. mem_write_data = req_wdata for a word store. For a sub-word store it is rd_q
//    with the addressed lane(s) replaced. Little-endian lanes: byte lane addr[1:0], half lane addr[1].
//    WR -> RESP.
//  - RESP: resp_valid=1 for exactly one cycle. For loads, resp_rdata = lane of rd_q, sign- or
//    zero-extended per req_signed. -> IDLE.
//  - Latency, accept edge to resp_valid high:
//    * word load and word store: 2 cycles
//    * sub-word store: 3 cycles
//    * error: 1 cycle
//  - Back-to-back: a new request can be accepted on the edge that leaves RESP at the earliest
//    (req_ready is high only in IDLE).
//  - req_* are ignored while req_ready=0. A request is not dropped while req_valid is held.
//  - req_signed is ignored for stores and for word loads.
//  - Reset mid-operation: at the rst edge -> IDLE, and no resp_valid is issued for the aborted
//    request. If rst is asserted during a WR cycle, that word write commits, because memory samples
//    the same edge. RMW is therefore never half-applied.
// STRUCTURE
//  - Package lsu_pkg: typedef enum {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD} size_e; state_e
//    {IDLE, RD, WR, RESP}; localparams ERR_OK, ERR_MISALIGN, ERR_RANGE, ERR_SIZE.
//  - One sub-module: lsu_lane_align (combinational). Inputs: word, addr[1:0], size, signed, wdata.
//    Outputs: extracted/extended load value and merged store word. The FSM stays in the top.
// TESTING
//  1. Word store 0xDEADBEEF @0x10, then word load @0x10 -> one mem_write cycle; load resp_rdata=0xDEADBEEF,
//     err=00, latency 2.
//  2. Mem word @0x20 = 0x11223344; SB 0xAA @0x21 -> RD then WR with mem_write_data=0x1122AA44; resp in 3 cycles.
//  3. Mem @0x20=0x8000FF7F: LB signed @0x20 -> 0x0000007F; LB signed @0x21 -> 0xFFFFFFFF; LHU @0x22 -> 0x00008000;
//     LH signed @0x22 -> 0xFFFF8000.
//  4. LH @0x03 -> err=01; LW @0x800 (MEM_WORDS=512) -> err=10; size=11 -> err=11. Each resp in 1 cycle,
//     mem_read=mem_write=0 throughout.
//  5. Issue SH, assert rst during its RD cycle -> IDLE next cycle, no mem_write, no resp_valid; memory unchanged.
//  6. Hold req_valid with 3 queued loads -> each accepted only when req_ready=1; resp_valid pulses once per request,
//     in order, no drops.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types, error codes and request-check helper for the
//               load/store unit.
// Revision    : 1.0  initial release
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_SIZE     = 2'b11;

  // Classify a request: bad size wins over misalignment, which wins over range.
  function automatic logic [1:0] req_error(input logic [1:0] size,
                                           input logic [1:0] addr_lo,
                                           input logic       in_range);
    logic [1:0] err;
    err = ERR_OK;
    if (size == SZ_RSVD)
      err = ERR_SIZE;
    else if ((size == SZ_HALF && addr_lo[0]) || (size == SZ_WORD && addr_lo != 2'b00))
      err = ERR_MISALIGN;
    else if (!in_range)
      err = ERR_RANGE;
    return err;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : lsu_if
// Description : Request/response channel between the execute stage and the
//               load/store unit.
// Revision    : 1.0  initial release
// ============================================================================
interface lsu_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic [1:0]            resp_err;

  // Datapath side: issues requests, receives responses.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Load/store unit side.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Little-endian lane extraction/extension for loads and lane
//               merge for sub-word stores over a 32-bit memory word.
// Revision    : 1.0  initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte and halfword lanes of the memory word.
  always_comb begin
    w_byte = word[7:0];
    case (addr_lo)
      2'b00:   w_byte = word[7:0];
      2'b01:   w_byte = word[15:8];
      2'b10:   w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    w_half = addr_lo[1] ? word[31:16] : word[15:0];
  end

  // Extend the selected lane; word accesses pass through untouched.
  always_comb begin
    load_val = word;
    case (size)
      SZ_BYTE: load_val = {{24{sign_ext & w_byte[7]}}, w_byte};
      SZ_HALF: load_val = {{16{sign_ext & w_half[15]}}, w_half};
      default: load_val = word;
    endcase
  end

  // Replace the addressed lane(s) with the right-justified store data.
  always_comb begin
    store_word = word;
    case (size)
      SZ_BYTE: begin
        case (addr_lo)
          2'b00:   store_word[7:0]   = wdata[7:0];
          2'b01:   store_word[15:8]  = wdata[7:0];
          2'b10:   store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (addr_lo[1])
          store_word[31:16] = wdata[15:0];
        else
          store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Sequences a word-addressed data memory for byte/half/word
//               loads and stores; sub-word stores use read-modify-write.
//               Bad requests are flagged and never touch memory.
// Revision    : 1.0  initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS  = 512,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  lsu_if.slave                  lsu,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [31:0]           mem_read_data
);

  localparam logic [1:0] c_st_idle = IDLE;
  localparam logic [1:0] c_st_rd   = RD;
  localparam logic [1:0] c_st_wr   = WR;
  localparam logic [1:0] c_st_resp = RESP;

  // First byte address past the end of the attached memory.
  localparam logic [ADDR_WIDTH:0] c_addr_limit = (ADDR_WIDTH+1)'(64'(MEM_WORDS) * 64'd4);

  logic [1:0]            r_state;
  logic                  r_write;
  logic [1:0]            r_size;
  logic                  r_signed;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [1:0]            r_err;
  logic [31:0]           r_rd_q;

  logic                  w_accept;
  logic                  w_in_range;
  logic [1:0]            w_req_err;
  logic [31:0]           w_load_val;
  logic [31:0]           w_store_word;
  logic                  w_mem_active;

  assign w_accept   = lsu.req_valid && (r_state == c_st_idle);
  assign w_in_range = ({1'b0, lsu.req_addr} < c_addr_limit);
  assign w_req_err  = req_error(lsu.req_size, lsu.req_addr[1:0], w_in_range);

  // Request latch, memory word capture and state sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_st_idle;
      r_write  <= 1'b0;
      r_size   <= 2'b00;
      r_signed <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= 32'h0;
      r_err    <= ERR_OK;
      r_rd_q   <= 32'h0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_write  <= lsu.req_write;
            r_size   <= lsu.req_size;
            r_signed <= lsu.req_signed;
            r_addr   <= lsu.req_addr;
            r_wdata  <= lsu.req_wdata;
            r_err    <= w_req_err;
            if (w_req_err != ERR_OK)
              r_state <= c_st_resp;
            else if (lsu.req_write && lsu.req_size == SZ_WORD)
              r_state <= c_st_wr;
            else
              r_state <= c_st_rd;
          end
        end
        c_st_rd: begin
          r_rd_q  <= mem_read_data;
          r_state <= r_write ? c_st_wr : c_st_resp;
        end
        c_st_wr:   r_state <= c_st_resp;
        default:   r_state <= c_st_idle;
      endcase
    end
  end

  lsu_lane_align u_lane_align (
    .word       (r_rd_q),
    .addr_lo    (r_addr[1:0]),
    .size       (r_size),
    .sign_ext   (r_signed),
    .wdata      (r_wdata),
    .load_val   (w_load_val),
    .store_word (w_store_word)
  );

  assign w_mem_active = (r_state == c_st_rd) || (r_state == c_st_wr);

  // Memory-side outputs are held at zero outside the RD/WR states.
  always_comb begin
    mem_read       = (r_state == c_st_rd);
    mem_write      = (r_state == c_st_wr);
    mem_address    = w_mem_active ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    mem_write_data = (r_state == c_st_wr) ? w_store_word : 32'h0;
  end

  // Handshake and response outputs; load data only for successful loads.
  always_comb begin
    lsu.req_ready  = (r_state == c_st_idle);
    lsu.resp_valid = (r_state == c_st_resp);
    lsu.resp_err   = (r_state == c_st_resp) ? r_err : ERR_OK;
    lsu.resp_rdata = (r_state == c_st_resp && !r_write && r_err == ERR_OK) ? w_load_val : 32'h0;
  end

endmodule
`default_nettype wire
